gftt_nms: RTL
=============

GFTT_NMS -- requirements
Module: gftt_nms

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: wdt_m1  in  11  image width minus 1.
REQ-004 SHALL have ports: hgt_m1  in  11  image height minus 1.
REQ-005 SHALL have ports: thresh  in  16  minimum eigenvalue score for a keypoint.
REQ-006 SHALL have ports: start  in  1  one-cycle frame-start pulse.
REQ-007 SHALL have ports: enb  in  1  block enable.
REQ-008 SHALL have ports: din  in  16  unsigned min-eigenvalue score, raster order; the gftt_eig dout stream.
REQ-009 SHALL have ports: vin  in  1  din valid qualifier; gaps allowed.
REQ-010 SHALL have ports: kp_x  out  11  keypoint column.
REQ-011 SHALL have ports: kp_y  out  11  keypoint row.
REQ-012 SHALL have ports: kp_score  out  16  keypoint score.
REQ-013 SHALL have ports: kp_valid  out  1  one-cycle keypoint strobe.
REQ-014 SHALL have ports: kp_cnt  out  16  keypoints emitted this frame, saturating.
REQ-015 SHALL have ports: done  out  1  one-cycle end-of-frame pulse.
REQ-016 SHALL sample wdt_m1, hgt_m1 and thresh only on the start cycle, and hold them for the whole frame.

Function
REQ-017 SHALL implement a state machine with states IDLE, RUN and DONE.
- IDLE->RUN on start&enb.
- RUN->DONE on acceptance of pixel (wdt_m1,hgt_m1).
- DONE->RUN on start&enb.
- Any state->IDLE when enb=0.
REQ-018 SHALL accept a pixel only when vin=1 in RUN; vin in IDLE or DONE SHALL be ignored.
REQ-019 SHALL track the pixel position with a column counter and a row counter: column wraps wdt_m1->0 and increments the row.
REQ-020 SHALL clear the counters on start; a vin in the start cycle SHALL be accepted as pixel (0,0).
REQ-021 SHALL hold two line buffers of 2048x16 plus a 3x3 window register, advancing only on accepted pixels.
REQ-022 SHALL evaluate centre C at (x,y)=(col-1,row-1) when pixel (col,row) is accepted with col>=2 and row>=2.
REQ-023 SHALL never emit border pixels: x=0, x=wdt_m1, y=0 and y=hgt_m1.
REQ-024 SHALL declare a keypoint when all of the following hold:
- C>=thresh;
- C > each of the 4 earlier-scanned neighbours (row y-1, and (x-1,y));
- C >= each of the 4 later-scanned neighbours ((x+1,y), and row y+1).
This is the tie rule that gives one winner per plateau.
REQ-025 SHALL assert kp_valid exactly 2 clk after the accepting vin cycle, with kp_x=x, kp_y=y, kp_score=C.
REQ-026 SHALL drive kp_x, kp_y and kp_score to 0 whenever kp_valid=0.
REQ-027 SHALL increment kp_cnt on each kp_valid, saturate at 16'hFFFF, and clear on start.
REQ-028 SHALL hold kp_cnt after done until the next start.
REQ-029 SHALL pulse done exactly 2 clk after acceptance of pixel (wdt_m1,hgt_m1); any keypoint from that pixel SHALL be on the same cycle as done.
REQ-030 SHALL, if wdt_m1<2 or hgt_m1<2, emit no keypoints while done still fires per REQ-029.
REQ-031 SHALL, on start in RUN (mid-frame), restart the frame; pipelined keypoints already in flight are discarded.
REQ-032 SHALL, on enb=0, squash in-flight kp_valid and done in the same cycle.
REQ-033 SHALL NOT clear line buffer contents on start; the row>=2 gating alone guarantees no stale data is used.

Reset
REQ-034 SHALL, on rst=1 at a clk edge, go to IDLE and clear counters, window, kp_* outputs, kp_cnt and done to 0.
REQ-035 SHALL give rst priority over start, enb and vin; rst mid-frame aborts the frame with no done.
REQ-036 SHALL NOT reset line buffer RAM contents.

Verification
REQ-037 Single peak -> exactly one keypoint.
- Stimulus: 8x6 frame (wdt_m1=7, hgt_m1=5), thresh=100, all pixels 10 except (3,2)=500, vin continuous.
- Response: one kp_valid with (3,2,500), 2 clk after pixel (4,3); kp_cnt=1; done 2 clk after pixel (7,5).
REQ-038 Plateau tie -> only the left pixel of the pair wins.
- Stimulus: same frame, (3,2)=(4,2)=500.
- Response: one keypoint at (3,2); kp_cnt=1.
REQ-039 Threshold and border -> no keypoints.
- Stimulus: peak 500 at (0,2) and peak 99 at (4,3), thresh=100.
- Response: no kp_valid; kp_cnt=0; done still pulses.
REQ-040 Gapped input -> results identical to continuous input.
- Stimulus: REQ-037 frame with vin toggling 1,0,0,1...
- Response: same keypoint values; kp_valid still 2 clk after pixel (4,3) is accepted.
REQ-041 Mid-frame restart -> old frame abandoned, new frame processed normally.
- Stimulus: start at pixel (5,3), then a full new REQ-037 frame.
- Response: the old-frame keypoint is suppressed if still in flight; new frame gives one keypoint and done; kp_cnt=1.
REQ-042 Control overrides -> outputs squashed or cleared.
- Stimulus: enb=0 for one cycle while kp_valid is pending; separately, rst mid-frame.
- Response: no kp_valid or done; state IDLE; all outputs 0.

Source files
------------

// File: rtl/gftt_nms.sv
// Non-maximum suppression over a raster stream of min-eigenvalue scores.
// Uses two line buffers and a 3x3 window, and emits one keypoint per local maximum.
module gftt_nms (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] wdt_m1,
  input  logic [10:0] hgt_m1,
  input  logic [15:0] thresh,
  input  logic        start,
  input  logic        enb,
  input  logic [15:0] din,
  input  logic        vin,
  output logic [10:0] kp_x,
  output logic [10:0] kp_y,
  output logic [15:0] kp_score,
  output logic        kp_valid,
  output logic [15:0] kp_cnt,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [10:0]            wdt_q, wdt_d, hgt_q, hgt_d;
  logic [15:0]            thr_q, thr_d;
  logic [10:0]            col_q, col_d, row_q, row_d;
  logic [2:0][2:0][15:0]  win_q, win_d;
  logic                   ev_q, ev_d, last_q, last_d;
  logic [10:0]            cx_q, cx_d, cy_q, cy_d;
  logic                   kp_valid_q, kp_valid_d, done_q, done_d;
  logic [10:0]            kp_x_q, kp_x_d, kp_y_q, kp_y_d;
  logic [15:0]            kp_score_q, kp_score_d, kp_cnt_q, kp_cnt_d;

  logic                   go, acc, is_last, peak;
  logic [10:0]            col_b, row_b, wdt_e, hgt_e;
  logic [15:0]            c;
  logic [1:0][15:0]       lb_rd;

  // Line buffer 0 holds the previous row, line buffer 1 the row before it.
  // The read address tracks the next column so the data is ready when the pixel arrives.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lb
    logic [15:0] mem [2048];
    logic [15:0] rd_q;
    logic [15:0] wr_data;
    if (gi == 0) begin : g_first
      assign wr_data = din;
    end else begin : g_next
      assign wr_data = lb_rd[gi-1];
    end
    always_ff @(posedge clk) begin
      if (acc) mem[col_b] <= wr_data;
      rd_q <= mem[col_d];
    end
    assign lb_rd[gi] = rd_q;
  end

  always_comb begin
    go      = start & enb;
    acc     = enb & vin & (go | (state_q == RUN));
    col_b   = go ? 11'd0 : col_q;
    row_b   = go ? 11'd0 : row_q;
    wdt_e   = go ? wdt_m1 : wdt_q;
    hgt_e   = go ? hgt_m1 : hgt_q;
    is_last = (col_b == wdt_e) && (row_b == hgt_e);

    state_d = state_q;
    wdt_d   = wdt_e;
    hgt_d   = hgt_e;
    thr_d   = go ? thresh : thr_q;
    col_d   = col_b;
    row_d   = row_b;
    win_d   = win_q;
    ev_d    = 1'b0;
    last_d  = 1'b0;
    cx_d    = col_b - 11'd1;
    cy_d    = row_b - 11'd1;

    if (acc) begin
      if (col_b == wdt_e) begin
        col_d = 11'd0;
        row_d = row_b + 11'd1;
      end else begin
        col_d = col_b + 11'd1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_rd[1];
      win_d[1][2] = lb_rd[0];
      win_d[2][2] = din;
      // col>=2 && row>=2 alone keeps the centre off every border.
      ev_d   = (col_b >= 11'd2) && (row_b >= 11'd2);
      last_d = is_last;
    end

    if (!enb)                state_d = IDLE;
    else if (acc && is_last) state_d = DONE;
    else if (go)             state_d = RUN;

    // Strict against earlier-scanned neighbours, non-strict against later ones: one winner per plateau.
    c    = win_q[1][1];
    peak = (c >= thr_q) &&
           (c >  win_q[0][0]) && (c >  win_q[0][1]) && (c >  win_q[0][2]) && (c > win_q[1][0]) &&
           (c >= win_q[1][2]) && (c >= win_q[2][0]) && (c >= win_q[2][1]) && (c >= win_q[2][2]);

    kp_valid_d = enb && !go && ev_q && peak;
    done_d     = enb && !go && last_q;
    kp_x_d     = kp_valid_d ? cx_q : 11'd0;
    kp_y_d     = kp_valid_d ? cy_q : 11'd0;
    kp_score_d = kp_valid_d ? c : 16'd0;

    kp_cnt_d = kp_cnt_q;
    if (go)                                      kp_cnt_d = 16'd0;
    else if (kp_valid_d && kp_cnt_q != 16'hFFFF) kp_cnt_d = kp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wdt_q      <= '0;
      hgt_q      <= '0;
      thr_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      ev_q       <= 1'b0;
      last_q     <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
      kp_valid_q <= 1'b0;
      done_q     <= 1'b0;
      kp_x_q     <= '0;
      kp_y_q     <= '0;
      kp_score_q <= '0;
      kp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wdt_q      <= wdt_d;
      hgt_q      <= hgt_d;
      thr_q      <= thr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      ev_q       <= ev_d;
      last_q     <= last_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      kp_valid_q <= kp_valid_d;
      done_q     <= done_d;
      kp_x_q     <= kp_x_d;
      kp_y_q     <= kp_y_d;
      kp_score_q <= kp_score_d;
      kp_cnt_q   <= kp_cnt_d;
    end
  end

  assign kp_valid = kp_valid_q;
  assign done     = done_q;
  assign kp_x     = kp_x_q;
  assign kp_y     = kp_y_q;
  assign kp_score = kp_score_q;
  assign kp_cnt   = kp_cnt_q;

endmodule
